// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub4_if.sv
// Operand/result handshake bundle for serial_sub4.
// A transfer happens on a rising edge where valid and ready are both 1; valid never depends on ready.
interface serial_sub4_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, d, bout, out_valid
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, d, bout, out_valid
  );

endinterface

// File: rtl/serial_sub4_full_sub.sv
// One-bit full subtractor: diff = x - y - bin, with borrow out.
module full_sub (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial unsigned subtractor: d = a - b computed LSB first, one bit per clock.
// bout is the final borrow, set exactly when a < b.
module serial_sub4
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_sub4_if.slave   bus,
  output state_t         state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             br;
  logic             bout_q;
  logic [CW-1:0]    cnt;
  logic             diff;
  logic             br_next;
  logic             accept;
  logic             last_bit;

  full_sub u_full_sub (
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (br),
    .diff (diff),
    .bout (br_next)
  );

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    accept        = 1'b0;
    last_bit      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        last_bit = (cnt == CW'(WIDTH - 1));
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        // Returning through IDLE means no new operand is taken on the release edge.
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      br     <= 1'b0;
      bout_q <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      sa  <= bus.a;
      sb  <= bus.b;
      br  <= 1'b0;
      cnt <= '0;
    end else if (state_q == CALC) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      // Each new bit enters at the MSB so the first (LSB) bit ends up in bit 0.
      res <= {diff, res[WIDTH-1:1]};
      br  <= br_next;
      cnt <= cnt + 1'b1;
      if (last_bit) bout_q <= br_next;
    end
  end

  assign bus.d     = res;
  assign bus.bout  = bout_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_sub4.sv
// Directed and randomized bench for serial_sub4 against an arithmetic reference model.
module tb_serial_sub4;
  import serial_sub_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t state_dbg;
  int     checks = 0;
  int     errors = 0;
  logic [W:0] exp_q[$];

  serial_sub4_if #(.WIDTH(W)) bus ();

  serial_sub4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain modular subtraction and an unsigned compare.
  function automatic logic [W:0] model(input int unsigned x, input int unsigned y);
    int dv;
    logic [W:0] r;
    dv = int'(x) - int'(y);
    if (dv < 0) dv = dv + (1 << W);
    r[W-1:0] = W'(dv);
    r[W]     = (x < y);
    return r;
  endfunction

  task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                     input bit noisy, output logic [W-1:0] got);
    logic [W:0] exp;
    int lat;
    @(negedge clk);
    check("in_ready_idle", bus.in_ready, 1);
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    exp_q.push_back(model(a, b));
    @(posedge clk); #1;
    if (!noisy) bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 4 * W + 8) begin
      if (noisy) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid) break;
      check("in_ready_calc", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    check("latency", lat, W);
    exp = exp_q.pop_front();
    got = bus.d;
    check("d", bus.d, exp[W-1:0]);
    check("bout", bus.bout, exp[W]);
    check("in_ready_done", bus.in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", bus.out_valid, 1);
      check("hold_d", bus.d, exp[W-1:0]);
      check("hold_bout", bus.bout, exp[W]);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", bus.out_valid, 0);
    check("release_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] got;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] s;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_d", bus.d, 0);
    check("rst_bout", bus.bout, 0);
    check("rst_state", state_dbg, IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    txn(4'd9, 4'd3, 0, 1'b0, got);
    txn(4'd3, 4'd9, 0, 1'b0, got);
    check("a3b9_d", got, 10);
    txn(4'd15, 4'd15, 0, 1'b0, got);
    check("equal_d", got, 0);
    txn(4'd0, 4'd1, 0, 1'b0, got);
    check("zero_minus_one_d", got, 15);
    txn(4'd12, 4'd5, 6, 1'b0, got);
    txn(4'd6, 4'd2, 0, 1'b1, got);
    check("noisy_first_pair_d", got, 4);

    // Reset in the second CALC cycle must discard the partial result.
    @(negedge clk);
    bus.a        = 4'd5;
    bus.b        = 4'd3;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_calc_state", state_dbg, CALC);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_d", bus.d, 0);
    check("midrst_bout", bus.bout, 0);
    check("midrst_state", state_dbg, IDLE);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_valid", bus.out_valid, 0);
    end
    txn(4'd8, 4'd1, 0, 1'b0, got);
    check("after_rst_d", got, 7);

    for (int i = 0; i < 20; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      txn(x, y, $urandom_range(0, 3), bit'($urandom_range(0, 1)), got);
    end

    // Adder partner: (x + y) - y must give back x.
    for (int i = 0; i < 8; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      s = x + y;
      txn(s, y, 0, 1'b0, got);
      check("add_sub_roundtrip", got, x);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
